// File: rtl/bus_client_gen.sv
// Bus-client traffic generator: LFSR-timed read/write requests inside a wrapping
// address window, with selectable traffic modes, read-back checking, timeout and counters.
module bus_client_gen #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ADDR_BEGIN     = 0,
    parameter int unsigned ADDR_END       = 3,
    parameter int unsigned LFSR_WIDTH     = 5,
    parameter int unsigned LFSR_TAPS      = 'b10100,
    parameter int unsigned LFSR_SEED      = 'b00101,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  rq,
    input  logic                  ack,
    output logic                  wr_ni,
    output logic [DATA_WIDTH-1:0] dataW,
    input  logic [DATA_WIDTH-1:0] dataR,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  txn_cnt,
    output logic                  timeout,
    output logic                  busy
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [ADDR_WIDTH-1:0] A_BEGIN    = ADDR_WIDTH'(ADDR_BEGIN);
    localparam logic [ADDR_WIDTH-1:0] A_END      = ADDR_WIDTH'(ADDR_END);
    localparam logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(LFSR_TAPS);
    localparam logic [LFSR_WIDTH-1:0] SEED       = (LFSR_WIDTH'(LFSR_SEED) == '0) ?
                                                   LFSR_WIDTH'(1) : LFSR_WIDTH'(LFSR_SEED);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    localparam logic [1:0] MODE_WR  = 2'b00;
    localparam logic [1:0] MODE_RD  = 2'b01;
    localparam logic [1:0] MODE_WRB = 2'b10;
    localparam logic [1:0] MODE_RND = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    typedef enum logic {PH_WRITE, PH_READ} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [1:0]            mode_q, mode_d;

    logic [ADDR_WIDTH-1:0] address_d;
    logic                  rq_d, wr_ni_d, rd_valid_d, timeout_d, busy_d;
    logic [DATA_WIDTH-1:0] dataW_d, rd_data_d;
    logic [CNT_WIDTH-1:0]  err_cnt_d, txn_cnt_d;

    logic [LFSR_WIDTH-1:0] lfsr_step;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] last_written;

    assign lfsr_step    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign addr_next    = (address == A_END) ? A_BEGIN : address + ADDR_ONE;
    assign last_written = dataW - DATA_ONE;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        lfsr_d     = lfsr_q;
        timer_d    = timer_q;
        mode_d     = mode_q;
        address_d  = address;
        wr_ni_d    = wr_ni;
        dataW_d    = dataW;
        rd_data_d  = rd_data;
        err_cnt_d  = err_cnt;
        txn_cnt_d  = txn_cnt;
        rd_valid_d = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                lfsr_d = lfsr_step;
                if (mode != MODE_WRB) phase_d = PH_WRITE;
                if (enable && lfsr_q[0]) begin
                    state_d = REQ;
                    timer_d = '0;
                    mode_d  = mode;
                    case (mode)
                        MODE_WR:  wr_ni_d = 1'b0;
                        MODE_RD:  wr_ni_d = 1'b1;
                        MODE_WRB: wr_ni_d = (phase_q == PH_READ);
                        MODE_RND: wr_ni_d = lfsr_q[1];
                        default:  wr_ni_d = 1'b1;
                    endcase
                end
            end
            REQ: begin
                if (ack) begin
                    state_d   = GAP;
                    txn_cnt_d = txn_cnt + CNT_ONE;
                    if (!wr_ni) begin
                        dataW_d = dataW + DATA_ONE;
                        if (mode_q == MODE_WRB) phase_d = PH_READ;
                        else                    address_d = addr_next;
                    end else begin
                        rd_data_d  = dataR;
                        rd_valid_d = 1'b1;
                        address_d  = addr_next;
                        if (mode_q == MODE_WRB) begin
                            phase_d = PH_WRITE;
                            if (dataR != last_written && err_cnt != '1)
                                err_cnt_d = err_cnt + CNT_ONE;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Abort without side effects so the same op is retried
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rq_d   = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= PH_WRITE;
            lfsr_q   <= SEED;
            timer_q  <= '0;
            mode_q   <= MODE_WR;
            address  <= A_BEGIN;
            rq       <= 1'b0;
            wr_ni    <= 1'b1;
            dataW    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err_cnt  <= '0;
            txn_cnt  <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            timer_q  <= timer_d;
            mode_q   <= mode_d;
            address  <= address_d;
            rq       <= rq_d;
            wr_ni    <= wr_ni_d;
            dataW    <= dataW_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            err_cnt  <= err_cnt_d;
            txn_cnt  <= txn_cnt_d;
            timeout  <= timeout_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_client_gen.sv
// Directed bench for bus_client_gen: write sweep, write/read-back with corruption,
// timeout retry, read-only wrap, reset mid-request and enable drop mid-request.
module tb_bus_client_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] address;
    logic       rq;
    logic       ack;
    logic       wr_ni;
    logic [7:0] dataW;
    logic [7:0] dataR;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [15:0] err_cnt;
    logic [15:0] txn_cnt;
    logic       timeout;
    logic       busy;

    logic       auto_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       use_fixed = 1'b0;
    logic       corrupt = 1'b0;
    logic [7:0] fixed_val = 8'h00;
    logic [7:0] mem [16];

    int tests = 0;
    int fails = 0;
    int n;
    int hi;
    int rq_seen;
    int gaps [5] = '{1, 4, 3, 5, 3};

    bus_client_gen dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .address  (address),
        .rq       (rq),
        .ack      (ack),
        .wr_ni    (wr_ni),
        .dataW    (dataW),
        .dataR    (dataR),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .err_cnt  (err_cnt),
        .txn_cnt  (txn_cnt),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Arbiter / memory model
    assign ack   = auto_ack ? rq : man_ack;
    assign dataR = (corrupt && wr_ni && address == 4'd2) ? 8'hFF :
                   (use_fixed ? fixed_val : mem[address]);

    always @(posedge clk) begin
        if (rq && ack && !wr_ni) mem[address] <= dataW;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rq"},       32'(rq),       32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_address"},  32'(address),  32'd0);
        chk({tag, "_dataW"},    32'(dataW),    32'd0);
        chk({tag, "_wr_ni"},    32'(wr_ni),    32'd1);
        chk({tag, "_txn"},      32'(txn_cnt),  32'd0);
        chk({tag, "_err"},      32'(err_cnt),  32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
        chk({tag, "_timeout"},  32'(timeout),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals(tag);
        reset = 1'b0;
    endtask

    // Waits (bounded) for rq; returns negedges waited
    task automatic wait_rq(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rq && cnt < 64);
        chk("rq_arrives", 32'(rq), 32'd1);
    endtask

    initial begin
        // 1: write-only sweep with LFSR timing and address wrap
        mode = 2'b00; enable = 1'b1; auto_ack = 1'b1;
        do_reset("t1_reset");
        for (int i = 0; i < 5; i++) begin
            wait_rq(n);
            chk("t1_gap",   32'(n),       32'(gaps[i]));
            chk("t1_addr",  32'(address), 32'(i % 4));
            chk("t1_dataW", 32'(dataW),   32'(i));
            chk("t1_wr_ni", 32'(wr_ni),   32'd0);
            if (i == 4) enable = 1'b0;
        end
        @(negedge clk);
        chk("t1_rq_gap",  32'(rq),       32'd0);
        chk("t1_txn",     32'(txn_cnt),  32'd5);
        chk("t1_addr_end", 32'(address), 32'd1);
        chk("t1_dataW_end", 32'(dataW),  32'd5);

        // 2: write-then-readback, read at address 2 corrupted
        mode = 2'b10; enable = 1'b1; auto_ack = 1'b1; corrupt = 1'b1;
        do_reset("t2_reset");
        for (int i = 0; i < 6; i++) begin
            wait_rq(n);
            chk("t2_wr_ni", 32'(wr_ni),   32'(i % 2));
            chk("t2_addr",  32'(address), 32'(i / 2));
            chk("t2_dataW", 32'(dataW),   32'(i / 2 + i % 2));
            if (i == 5) enable = 1'b0;
            if (i % 2 == 1) begin
                @(negedge clk);
                chk("t2_rd_valid", 32'(rd_valid), 32'd1);
                chk("t2_rd_data",  32'(rd_data),  (i == 5) ? 32'hFF : 32'(i / 2));
                if (i == 3) chk("t2_err_clean", 32'(err_cnt), 32'd0);
            end
        end
        chk("t2_err",  32'(err_cnt), 32'd1);
        chk("t2_addr_adv", 32'(address), 32'd3);
        chk("t2_txn",  32'(txn_cnt), 32'd6);
        corrupt = 1'b0;

        // 3: timeout after 16 REQ cycles, then retry of the same op
        mode = 2'b00; enable = 1'b1; auto_ack = 1'b0; man_ack = 1'b0;
        do_reset("t3_reset");
        wait_rq(n);
        hi = 1;
        do begin
            @(negedge clk);
            if (rq) hi++;
        end while (rq && hi < 40);
        chk("t3_rq_high",   32'(hi),      32'd16);
        chk("t3_timeout",   32'(timeout), 32'd1);
        chk("t3_gap_rq",    32'(rq),      32'd0);
        chk("t3_gap_busy",  32'(busy),    32'd1);
        chk("t3_txn_abort", 32'(txn_cnt), 32'd0);
        auto_ack = 1'b1;
        @(negedge clk);
        chk("t3_timeout_pulse", 32'(timeout), 32'd0);
        chk("t3_rq_after_gap",  32'(rq),      32'd0);
        wait_rq(n);
        chk("t3_retry_addr",  32'(address), 32'd0);
        chk("t3_retry_dataW", 32'(dataW),   32'd0);
        chk("t3_retry_wr_ni", 32'(wr_ni),   32'd0);
        enable = 1'b0;
        @(negedge clk);
        chk("t3_txn_done", 32'(txn_cnt), 32'd1);

        // 4: read-only with fixed read data, address wrap
        mode = 2'b01; enable = 1'b1; auto_ack = 1'b1; use_fixed = 1'b1; fixed_val = 8'hA5;
        do_reset("t4_reset");
        for (int i = 0; i < 5; i++) begin
            wait_rq(n);
            chk("t4_addr",  32'(address), 32'(i % 4));
            chk("t4_wr_ni", 32'(wr_ni),   32'd1);
            chk("t4_rd_valid_early", 32'(rd_valid), 32'd0);
            if (i == 4) enable = 1'b0;
            @(negedge clk);
            chk("t4_rd_valid", 32'(rd_valid), 32'd1);
            chk("t4_rd_data",  32'(rd_data),  32'hA5);
            @(negedge clk);
            chk("t4_rd_valid_pulse", 32'(rd_valid), 32'd0);
        end
        chk("t4_err",  32'(err_cnt), 32'd0);
        chk("t4_txn",  32'(txn_cnt), 32'd5);
        chk("t4_addr_end", 32'(address), 32'd1);
        use_fixed = 1'b0;

        // 5: reset while in REQ, LFSR timing restarts identically
        mode = 2'b00; enable = 1'b1; auto_ack = 1'b0; man_ack = 1'b0;
        do_reset("t5_reset");
        wait_rq(n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t5_mid_req");
        auto_ack = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_rq(n);
            chk("t5_gap",  32'(n),       32'(gaps[i]));
            chk("t5_addr", 32'(address), 32'(i));
            if (i == 2) enable = 1'b0;
        end
        @(negedge clk);
        chk("t5_txn", 32'(txn_cnt), 32'd3);

        // 6: enable dropped mid-REQ; ack outside REQ ignored
        mode = 2'b00; enable = 1'b1; auto_ack = 1'b0; man_ack = 1'b0;
        do_reset("t6_reset");
        wait_rq(n);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rq_held", 32'(rq), 32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        chk("t6_rq_drop", 32'(rq),       32'd0);
        chk("t6_txn",     32'(txn_cnt),  32'd1);
        chk("t6_addr",    32'(address),  32'd1);
        chk("t6_dataW",   32'(dataW),    32'd1);
        rq_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rq) rq_seen++;
        end
        man_ack = 1'b0;
        chk("t6_no_new_rq",   32'(rq_seen), 32'd0);
        chk("t6_txn_ignored", 32'(txn_cnt), 32'd1);
        chk("t6_idle_busy",   32'(busy),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
